fetch_queue: RTL

- Parametrised instruction-fetch stage for the fetch/decode/execute pipeline.
- Generates sequential PCs and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a DEPTH-entry FIFO and presents {pc, instr} to decode with a valid/ready handshake.
- Supports stall (decode not ready) and branch redirect/flush from execute.

---
 rtl/fetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: sequential PC generation, 1-cycle-latency imem requests, DEPTH-entry {pc, instr} queue.
// Optional FETCH_PERF_CNT_EN adds saturating stall-cycle and flushed-entry counters.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         if_id_valid,
  input  logic                         if_id_ready,
  output logic [ADDR_W+INSTR_W-1:0]    if_id_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]      DEPTH_C  = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]   STEP_C   = ADDR_W'(PC_STEP);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH-1);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               pop;
  logic               push;
  logic [CNT_W:0]     proj_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign occupancy   = count_q;
  assign if_id_valid = (count_q != '0) & ~redirect;
  assign pop         = if_id_valid & if_id_ready;
  assign push        = inflight_q & ~redirect;
  // Count after this edge if we issue now: guarantees room for every response.
  assign proj_count  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign imem_req    = ~reset & ~redirect & (proj_count < DEPTH_C);
  assign imem_addr   = pc_q;
  assign if_id_data  = {pc_mem[rd_ptr_q], instr_mem[rd_ptr_q]};

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q     <= pc_q + STEP_C;
        req_pc_q <= pc_q;
      end
      if (push) begin
        pc_mem[wr_ptr_q]    <= req_pc_q;
        instr_mem[wr_ptr_q] <= imem_rdata;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, perf_flushed} + 33'(count_q) + 33'(inflight_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushed      <= '0;
    end else begin
      if (if_id_valid && !if_id_ready && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (redirect)
        perf_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule
